// File: rtl/bus_arbiter_if.sv
// Arbiter bus bundle: per-source requests and payloads in, one registered
// transfer out. The source/consumer side uses master, the arbiter uses slave.
interface bus_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int N_SRC = 3
);
   localparam int OW = $clog2(N_SRC);

   logic [N_SRC-1:0]       req;
   logic [N_SRC*WIDTH-1:0] data_in;
   logic                   out_ready;
   logic [N_SRC-1:0]       grant;
   logic [WIDTH-1:0]       data_out;
   logic                   out_valid;
   logic [OW-1:0]          owner;

   modport master (
      output req, data_in, out_ready,
      input  grant, data_out, out_valid, owner
   );

   modport slave (
      input  req, data_in, out_ready,
      output grant, data_out, out_valid, owner
   );
endinterface

// File: rtl/bus_arbiter.sv
// N-source arbiter feeding a single registered output stage, selectable
// fixed-priority or round-robin, sustaining one transfer per cycle.
module bus_arbiter #(
   parameter int WIDTH = 32,
   parameter int N_SRC = 3,
   parameter int RR    = 0
) (
   input logic          clk,
   input logic          rst,
   bus_arbiter_if.slave bus
);
   localparam int                OW          = $clog2(N_SRC);
   localparam logic [OW-1:0]     LAST_RST    = OW'(N_SRC - 32'sd1);
   localparam logic [N_SRC-1:0]  SRC0_ONEHOT = N_SRC'(1'b1);

   logic [WIDTH-1:0] data_r;
   logic             valid_r;
   logic [OW-1:0]    owner_r;
   logic [OW-1:0]    last_r;

   logic             free_s;
   logic             any_req_s;
   logic [OW-1:0]    start_s;
   logic [OW-1:0]    winner_s;
   logic [N_SRC-1:0] grant_s;
   logic [WIDTH-1:0] win_data_s;

   // Wraps at N_SRC-1 explicitly so non-power-of-two source counts never
   // visit a non-existent index.
   function automatic logic [OW-1:0] next_index(input logic [OW-1:0] idx);
      next_index = (int'(idx) == (N_SRC - 32'sd1)) ? {OW{1'b0}} : idx + 1'b1;
   endfunction

   function automatic logic [OW-1:0] first_set(input logic [N_SRC-1:0] req_v,
                                               input logic [OW-1:0]    start);
      logic [OW-1:0] idx;
      logic          found;
      logic          hit;
      first_set = start;
      found     = 1'b0;
      idx       = start;
      for (int k = 32'sd0; k < N_SRC; k++) begin
         hit       = ~found & req_v[idx];
         first_set = hit ? idx : first_set;
         found     = found | hit;
         idx       = next_index(idx);
      end
   endfunction

   // Search origin: fixed priority always scans from source 0, round-robin
   // resumes just after the previous winner.
   always_comb begin
      if (RR != 32'sd0) begin
         start_s = next_index(last_r);
      end else begin
         start_s = {OW{1'b0}};
      end
   end

   // Winner selection, payload mux and combinational grant
   always_comb begin
      any_req_s  = |bus.req;
      free_s     = ~valid_r | bus.out_ready;
      winner_s   = first_set(bus.req, start_s);
      win_data_s = {WIDTH{1'b0}};
      for (int i = 32'sd0; i < N_SRC; i++) begin
         win_data_s = (winner_s == OW'(i)) ? bus.data_in[i*WIDTH +: WIDTH] : win_data_s;
      end
      if (!rst && free_s && any_req_s) begin
         grant_s = SRC0_ONEHOT << winner_s;
      end else begin
         grant_s = {N_SRC{1'b0}};
      end
   end

   // Output stage: capture when free, clear when free and idle, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= {WIDTH{1'b0}};
         owner_r <= {OW{1'b0}};
         last_r  <= LAST_RST;
      end else if (free_s && any_req_s) begin
         valid_r <= 1'b1;
         data_r  <= win_data_s;
         owner_r <= winner_s;
         last_r  <= winner_s;
      end else if (free_s) begin
         valid_r <= 1'b0;
         data_r  <= {WIDTH{1'b0}};
      end
   end

   assign bus.grant     = grant_s;
   assign bus.data_out  = data_r;
   assign bus.out_valid = valid_r;
   assign bus.owner     = owner_r;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: fixed-priority (3 src), round-robin
// (3 src) and round-robin (5 src) instances share one clock and reset.
module tb_bus_arbiter;
   localparam int W = 32;

   typedef struct {
      int         owner;
      logic [W-1:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_arbiter_if #(.WIDTH(W), .N_SRC(3)) if_fp ();
   bus_arbiter_if #(.WIDTH(W), .N_SRC(3)) if_rr ();
   bus_arbiter_if #(.WIDTH(W), .N_SRC(5)) if_rr5 ();

   bus_arbiter #(.WIDTH(W), .N_SRC(3), .RR(0)) dut_fp  (.clk(clk), .rst(rst), .bus(if_fp));
   bus_arbiter #(.WIDTH(W), .N_SRC(3), .RR(1)) dut_rr  (.clk(clk), .rst(rst), .bus(if_rr));
   bus_arbiter #(.WIDTH(W), .N_SRC(5), .RR(1)) dut_rr5 (.clk(clk), .rst(rst), .bus(if_rr5));

   xfer_t sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    rr_last;

   // Reference pick: scan the circular order backwards so the earliest hit wins.
   function automatic int pick(input logic [15:0] req, input int n, input int last, input bit rr);
      int start;
      int i;
      start = rr ? (last + 1) % n : 0;
      pick  = -1;
      for (int k = n - 1; k >= 0; k--) begin
         i = (start + k) % n;
         if (req[i]) pick = i;
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      if_fp.req = 3'b111;  if_fp.data_in = {$urandom, $urandom, $urandom};  if_fp.out_ready = 1'b1;
      if_rr.req = 3'b111;  if_rr.data_in = {$urandom, $urandom, $urandom};  if_rr.out_ready = 1'b1;
      if_rr5.req = 5'b11111;
      if_rr5.data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if_rr5.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (if_fp.grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant_fp got=%b exp=000", if_fp.grant); end
      n_checks++;
      if (if_rr.grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant_rr got=%b exp=000", if_rr.grant); end
      n_checks++;
      if (if_rr5.grant !== 5'b00000) begin n_fail++; $display("FAIL reset_grant_rr5 got=%b exp=00000", if_rr5.grant); end
      n_checks++;
      if (if_fp.out_valid !== 1'b0 || if_fp.data_out !== 32'h0 || if_fp.owner !== 2'd0) begin
         n_fail++; $display("FAIL reset_out_fp got v=%b d=%h o=%0d exp v=0 d=0 o=0", if_fp.out_valid, if_fp.data_out, if_fp.owner);
      end
      n_checks++;
      if (if_rr5.out_valid !== 1'b0 || if_rr5.data_out !== 32'h0 || if_rr5.owner !== 3'd0) begin
         n_fail++; $display("FAIL reset_out_rr5 got v=%b d=%h o=%0d exp v=0 d=0 o=0", if_rr5.out_valid, if_rr5.data_out, if_rr5.owner);
      end
      rst = 1'b0;
      if_fp.req = 3'b000; if_rr.req = 3'b000; if_rr5.req = 5'b00000;
      rr_last = 2;
      @(posedge clk); #1;
      n_checks++;
      if (if_rr.out_valid !== 1'b0 || if_rr.data_out !== 32'h0) begin
         n_fail++; $display("FAIL idle_after_reset got v=%b d=%h exp v=0 d=0", if_rr.out_valid, if_rr.data_out);
      end
   endtask

   task automatic test_fixed_priority();
      logic [2:0] pats [6] = '{3'b111, 3'b111, 3'b011, 3'b110, 3'b100, 3'b101};
      int         expw [6] = '{0, 0, 0, 1, 2, 0};
      xfer_t      e;
      for (int p = 0; p < 6; p++) begin
         @(negedge clk);
         if_fp.req = pats[p]; if_fp.data_in = {$urandom, $urandom, $urandom}; if_fp.out_ready = 1'b1;
         #1;
         n_checks++;
         if (if_fp.grant !== (3'b001 << expw[p])) begin
            n_fail++; $display("FAIL fp_grant[%0d] got=%b exp=%b", p, if_fp.grant, 3'b001 << expw[p]);
         end
         sb_q.push_back('{expw[p], if_fp.data_in[expw[p]*W +: W]});
         @(posedge clk); #1;
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++; $display("FAIL fp_sb[%0d] scoreboard empty", p);
         end else begin
            e = sb_q.pop_front();
            if (if_fp.out_valid !== 1'b1 || if_fp.data_out !== e.data || if_fp.owner !== e.owner[1:0]) begin
               n_fail++; $display("FAIL fp_out[%0d] got v=%b d=%h o=%0d exp v=1 d=%h o=%0d", p, if_fp.out_valid, if_fp.data_out, if_fp.owner, e.data, e.owner);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      xfer_t e;
      @(negedge clk);
      if_fp.req = 3'b010; if_fp.data_in = {$urandom, 32'h0000_1234, $urandom}; if_fp.out_ready = 1'b1;
      sb_q.push_back('{1, 32'h0000_1234});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (if_fp.out_valid !== 1'b1 || if_fp.data_out !== e.data || if_fp.owner !== 2'd1) begin
         n_fail++; $display("FAIL bp_load got v=%b d=%h o=%0d exp v=1 d=%h o=1", if_fp.out_valid, if_fp.data_out, if_fp.owner, e.data);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if_fp.req = 3'b111; if_fp.data_in = {$urandom, $urandom, $urandom}; if_fp.out_ready = 1'b0;
         #1;
         n_checks++;
         if (if_fp.grant !== 3'b000) begin n_fail++; $display("FAIL bp_grant[%0d] got=%b exp=000", c, if_fp.grant); end
         @(posedge clk); #1;
         n_checks++;
         if (if_fp.out_valid !== 1'b1 || if_fp.data_out !== 32'h0000_1234 || if_fp.owner !== 2'd1) begin
            n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h o=%0d exp v=1 d=00001234 o=1", c, if_fp.out_valid, if_fp.data_out, if_fp.owner);
         end
      end
      @(negedge clk);
      if_fp.out_ready = 1'b1;
      #1;
      n_checks++;
      if (if_fp.grant !== 3'b001) begin n_fail++; $display("FAIL bp_release_grant got=%b exp=001", if_fp.grant); end
      sb_q.push_back('{0, if_fp.data_in[W-1:0]});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (if_fp.data_out !== e.data || if_fp.owner !== 2'd0) begin
         n_fail++; $display("FAIL bp_release_out got d=%h o=%0d exp d=%h o=0", if_fp.data_out, if_fp.owner, e.data);
      end
   endtask

   task automatic test_drain();
      @(negedge clk);
      if_fp.req = 3'b100; if_fp.data_in = {32'hCCCC_0002, $urandom, $urandom}; if_fp.out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (if_fp.data_out !== 32'hCCCC_0002 || if_fp.owner !== 2'd2) begin
         n_fail++; $display("FAIL drain_load got d=%h o=%0d exp d=cccc0002 o=2", if_fp.data_out, if_fp.owner);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if_fp.req = 3'b000;
         #1;
         n_checks++;
         if (if_fp.grant !== 3'b000) begin n_fail++; $display("FAIL drain_grant[%0d] got=%b exp=000", c, if_fp.grant); end
         @(posedge clk); #1;
         n_checks++;
         if (if_fp.out_valid !== 1'b0 || if_fp.data_out !== 32'h0 || if_fp.owner !== 2'd2) begin
            n_fail++; $display("FAIL drain_out[%0d] got v=%b d=%h o=%0d exp v=0 d=0 o=2", c, if_fp.out_valid, if_fp.data_out, if_fp.owner);
         end
      end
   endtask

   task automatic test_round_robin();
      int         seq [6] = '{0, 1, 2, 0, 1, 2};
      logic [2:0] pats [8] = '{3'b101, 3'b101, 3'b011, 3'b010, 3'b010, 3'b111, 3'b111, 3'b111};
      bit         rdy  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      int         cnt [3] = '{0, 0, 0};
      int         w;
      xfer_t      e;
      xfer_t      held;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if_rr.req = 3'b111; if_rr.data_in = {$urandom, $urandom, $urandom}; if_rr.out_ready = 1'b1;
         #1;
         n_checks++;
         if (if_rr.grant !== (3'b001 << seq[c])) begin
            n_fail++; $display("FAIL rr_seq_grant[%0d] got=%b exp=%b", c, if_rr.grant, 3'b001 << seq[c]);
         end
         for (int s = 0; s < 3; s++) if (if_rr.grant[s]) cnt[s]++;
         sb_q.push_back('{seq[c], if_rr.data_in[seq[c]*W +: W]});
         @(posedge clk); #1;
         e = sb_q.pop_front();
         n_checks++;
         if (if_rr.data_out !== e.data || if_rr.owner !== e.owner[1:0]) begin
            n_fail++; $display("FAIL rr_seq_out[%0d] got d=%h o=%0d exp d=%h o=%0d", c, if_rr.data_out, if_rr.owner, e.data, e.owner);
         end
      end
      rr_last = 2;
      for (int s = 0; s < 3; s++) begin
         n_checks++;
         if (cnt[s] != 2) begin n_fail++; $display("FAIL rr_fair[%0d] got=%0d exp=2", s, cnt[s]); end
      end
      held = e;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if_rr.req = pats[c]; if_rr.data_in = {$urandom, $urandom, $urandom}; if_rr.out_ready = rdy[c];
         #1;
         n_checks++;
         if (rdy[c]) begin
            w = pick(16'(pats[c]), 3, rr_last, 1'b1);
            if (if_rr.grant !== (3'b001 << w)) begin
               n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, if_rr.grant, 3'b001 << w);
            end
            sb_q.push_back('{w, if_rr.data_in[w*W +: W]});
            rr_last = w;
         end else if (if_rr.grant !== 3'b000) begin
            n_fail++; $display("FAIL rr_bp_grant[%0d] got=%b exp=000", c, if_rr.grant);
         end
         @(posedge clk); #1;
         if (rdy[c]) held = sb_q.pop_front();
         n_checks++;
         if (if_rr.out_valid !== 1'b1 || if_rr.data_out !== held.data || if_rr.owner !== held.owner[1:0]) begin
            n_fail++; $display("FAIL rr_out[%0d] got v=%b d=%h o=%0d exp v=1 d=%h o=%0d", c, if_rr.out_valid, if_rr.data_out, if_rr.owner, held.data, held.owner);
         end
      end
      @(negedge clk);
      if_rr.req = 3'b000;
   endtask

   task automatic test_rr_wrap5();
      logic [4:0] pats [7] = '{5'b10001, 5'b10001, 5'b10001, 5'b00100, 5'b00100, 5'b01010, 5'b01010};
      int         expw [7] = '{0, 4, 0, 2, 2, 3, 1};
      xfer_t      e;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if_rr5.req = pats[c];
         if_rr5.data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
         if_rr5.out_ready = 1'b1;
         #1;
         n_checks++;
         if (if_rr5.grant !== (5'b00001 << expw[c])) begin
            n_fail++; $display("FAIL rr5_grant[%0d] got=%b exp=%b", c, if_rr5.grant, 5'b00001 << expw[c]);
         end
         sb_q.push_back('{expw[c], if_rr5.data_in[expw[c]*W +: W]});
         @(posedge clk); #1;
         e = sb_q.pop_front();
         n_checks++;
         if (if_rr5.data_out !== e.data || if_rr5.owner !== e.owner[2:0]) begin
            n_fail++; $display("FAIL rr5_out[%0d] got d=%h o=%0d exp d=%h o=%0d", c, if_rr5.data_out, if_rr5.owner, e.data, e.owner);
         end
      end
      @(negedge clk);
      if_rr5.req = 5'b00000;
   endtask

   task automatic test_reset_mid();
      int    w;
      xfer_t e;
      @(negedge clk);
      if_rr.req = 3'b110; if_rr.data_in = {$urandom, $urandom, $urandom}; if_rr.out_ready = 1'b1;
      w = pick(16'(3'b110), 3, rr_last, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (if_rr.out_valid !== 1'b1 || if_rr.owner !== 2'(w)) begin
         n_fail++; $display("FAIL rmid_load got v=%b o=%0d exp v=1 o=%0d", if_rr.out_valid, if_rr.owner, w);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (if_rr.grant !== 3'b000) begin n_fail++; $display("FAIL rmid_grant got=%b exp=000", if_rr.grant); end
      @(posedge clk); #1;
      n_checks++;
      if (if_rr.out_valid !== 1'b0 || if_rr.data_out !== 32'h0 || if_rr.owner !== 2'd0 || if_rr.grant !== 3'b000) begin
         n_fail++; $display("FAIL rmid_out got v=%b d=%h o=%0d g=%b exp v=0 d=0 o=0 g=000", if_rr.out_valid, if_rr.data_out, if_rr.owner, if_rr.grant);
      end
      @(negedge clk);
      rst = 1'b0; if_rr.req = 3'b000;
      @(posedge clk); #1;
      n_checks++;
      if (if_rr.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got v=%b exp v=0", if_rr.out_valid); end
      @(negedge clk);
      if_rr.req = 3'b111; if_rr.data_in = {$urandom, $urandom, $urandom};
      #1;
      n_checks++;
      if (if_rr.grant !== 3'b001) begin n_fail++; $display("FAIL rmid_first_grant got=%b exp=001", if_rr.grant); end
      sb_q.push_back('{0, if_rr.data_in[W-1:0]});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (if_rr.out_valid !== 1'b1 || if_rr.data_out !== e.data || if_rr.owner !== 2'd0) begin
         n_fail++; $display("FAIL rmid_first_out got v=%b d=%h o=%0d exp v=1 d=%h o=0", if_rr.out_valid, if_rr.data_out, if_rr.owner, e.data);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (if_rr.grant !== 3'b010) begin n_fail++; $display("FAIL rmid_second_grant got=%b exp=010", if_rr.grant); end
      if_rr.req = 3'b000;
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_backpressure();
      test_drain();
      test_round_robin();
      test_rr_wrap5();
      test_reset_mid();
      n_checks++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
